// File: rtl/cross_clock_fifo.sv
// Single-clock circular word FIFO used as the frame queue between the
// forwarding push side and the MAC pop side. Free space is reported on the
// write side and occupancy on the read side; all status outputs are registered.
module cross_clock_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 256,
  parameter bit          USE_BLOCK = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [$clog2(DEPTH):0]   wr_size,
  output logic                     wr_full,
  output logic                     wr_overflow,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   rd_size,
  output logic                     rd_empty,
  output logic                     rd_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    rd_size_q, rd_size_d;
  logic [CW-1:0]    wr_size_q, wr_size_d;
  logic             rd_empty_q, rd_empty_d;
  logic             wr_full_q, wr_full_d;
  logic             wr_overflow_q, wr_overflow_d;
  logic             rd_underflow_q, rd_underflow_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ok_c;
  logic             rd_ok_c;

  // Accept/reject decisions and next status, judged on the registered flags.
  always_comb begin
    wr_ok_c        = 1'b0;
    rd_ok_c        = 1'b0;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rd_size_d      = rd_size_q;
    wr_size_d      = wr_size_q;
    rd_empty_d     = rd_empty_q;
    wr_full_d      = wr_full_q;
    wr_overflow_d  = 1'b0;
    rd_underflow_d = 1'b0;

    wr_ok_c = rst_n && wr_en && !wr_full_q;
    rd_ok_c = rst_n && rd_en && !rd_empty_q;

    if (wr_ok_c) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (rd_ok_c) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end

    rd_size_d      = wr_ptr_d - rd_ptr_d;
    wr_size_d      = CW'(DEPTH) - rd_size_d;
    rd_empty_d     = (rd_size_d == '0);
    wr_full_d      = (wr_size_d == '0);
    wr_overflow_d  = wr_en && wr_full_q;
    rd_underflow_d = rd_en && rd_empty_q;
  end

  // Pointer and status registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_size_q      <= '0;
      wr_size_q      <= CW'(DEPTH);
      rd_empty_q     <= 1'b1;
      wr_full_q      <= 1'b0;
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_size_q      <= rd_size_d;
      wr_size_q      <= wr_size_d;
      rd_empty_q     <= rd_empty_d;
      wr_full_q      <= wr_full_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  // Storage: identical behaviour either way, the branch only steers mapping.
  if (USE_BLOCK) begin : g_block_ram
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (wr_ok_c) begin
        mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
    end

    // Registered read port; holds its value between successful reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q <= '0;
      end else if (rd_ok_c) begin
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end else begin : g_dist_ram
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (wr_ok_c) begin
        mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
    end

    // Registered read port; holds its value between successful reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q <= '0;
      end else if (rd_ok_c) begin
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign wr_size      = wr_size_q;
  assign wr_full      = wr_full_q;
  assign wr_overflow  = wr_overflow_q;
  assign rd_data      = rd_data_q;
  assign rd_size      = rd_size_q;
  assign rd_empty     = rd_empty_q;
  assign rd_underflow = rd_underflow_q;

endmodule

// File: tb/tb_cross_clock_fifo.sv
// Bench for cross_clock_fifo at DEPTH=8, WIDTH=8: a table of hand-derived
// vectors, directed corner sequences, then random traffic against a queue model.
module tb_cross_clock_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [CW-1:0] wr_size;
  logic          wr_full;
  logic          wr_overflow;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] rd_size;
  logic          rd_empty;
  logic          rd_underflow;

  cross_clock_fifo #(.WIDTH(W), .DEPTH(D), .USE_BLOCK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_size(wr_size),
    .wr_full(wr_full), .wr_overflow(wr_overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_size(rd_size),
    .rd_empty(rd_empty), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of stored words plus the last word read out.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_data = '0;
  logic         m_ovf  = 1'b0;
  logic         m_unf  = 1'b0;

  typedef struct {
    logic         rst;
    logic         we;
    logic [W-1:0] wd;
    logic         re;
    int           e_rd_size;
    int           e_wr_size;
    int           e_empty;
    int           e_full;
    int           e_ovf;
    int           e_unf;
    int           e_data;
  } vec_t;

  task automatic chk(input string tag, input string field, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", tag, field, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input logic r, input logic we, input logic [W-1:0] wd, input logic re);
    bit was_full, was_empty;
    rst_n   = r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_data = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      m_ovf = we && was_full;
      m_unf = re && was_empty;
      if (re && !was_empty) m_data = mq.pop_front();
      if (we && !was_full) mq.push_back(wd);
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk(tag, "rd_size",      int'(rd_size),      mq.size());
    chk(tag, "wr_size",      int'(wr_size),      D - mq.size());
    chk(tag, "rd_empty",     int'(rd_empty),     int'(mq.size() == 0));
    chk(tag, "wr_full",      int'(wr_full),      int'(mq.size() == D));
    chk(tag, "wr_overflow",  int'(wr_overflow),  int'(m_ovf));
    chk(tag, "rd_underflow", int'(rd_underflow), int'(m_unf));
    chk(tag, "rd_data",      int'(rd_data),      int'(m_data));
    chk(tag, "size_sum",     int'(wr_size) + int'(rd_size), D);
  endtask

  vec_t vt[$];

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    // rst we wd re | rd_size wr_size empty full ovf unf data
    vt.push_back('{1'b0, 1'b1, 8'h99, 1'b1, 0, 8, 1, 0, 0, 0, 8'h00});
    vt.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 1, 7, 0, 0, 0, 0, 8'h00});
    vt.push_back('{1'b1, 1'b1, 8'h22, 1'b0, 2, 6, 0, 0, 0, 0, 8'h00});
    vt.push_back('{1'b1, 1'b1, 8'h33, 1'b0, 3, 5, 0, 0, 0, 0, 8'h00});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 2, 6, 0, 0, 0, 0, 8'h11});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 2, 6, 0, 0, 0, 0, 8'h11});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1, 7, 0, 0, 0, 0, 8'h22});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 0, 8, 1, 0, 0, 0, 8'h33});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 0, 8, 1, 0, 0, 1, 8'h33});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 0, 8, 1, 0, 0, 0, 8'h33});
    vt.push_back('{1'b1, 1'b1, 8'h44, 1'b1, 1, 7, 0, 0, 0, 1, 8'h33});
    vt.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 0, 8, 1, 0, 0, 0, 8'h44});

    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].we, vt[i].wd, vt[i].re);
      chk($sformatf("vec%0d", i), "rd_size",      int'(rd_size),      vt[i].e_rd_size);
      chk($sformatf("vec%0d", i), "wr_size",      int'(wr_size),      vt[i].e_wr_size);
      chk($sformatf("vec%0d", i), "rd_empty",     int'(rd_empty),     vt[i].e_empty);
      chk($sformatf("vec%0d", i), "wr_full",      int'(wr_full),      vt[i].e_full);
      chk($sformatf("vec%0d", i), "wr_overflow",  int'(wr_overflow),  vt[i].e_ovf);
      chk($sformatf("vec%0d", i), "rd_underflow", int'(rd_underflow), vt[i].e_unf);
      chk($sformatf("vec%0d", i), "rd_data",      int'(rd_data),      vt[i].e_data);
    end

    // Fill to full, then a rejected ninth write.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, W'(8'h10 + i), 1'b0);
      chk_model("fill");
    end
    chk("fill", "wr_full", int'(wr_full), 1);
    chk("fill", "wr_size", int'(wr_size), 0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("ovf", "wr_overflow", int'(wr_overflow), 1);
    chk_model("ovf");
    step(1'b1, 1'b0, '0, 1'b0);
    chk("ovf_end", "wr_overflow", int'(wr_overflow), 0);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      chk_model("drain");
      chk("drain", "rd_data_is_AA", int'(rd_data == 8'hAA), 0);
    end

    // Read while empty keeps the last word and pulses underflow once.
    chk("under", "rd_data_last", int'(rd_data), 8'h17);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("under", "rd_underflow", int'(rd_underflow), 1);
    chk("under", "rd_data_hold", int'(rd_data), 8'h17);
    chk("under", "rd_size", int'(rd_size), 0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk_model("under_end");

    // Steady stream at occupancy 4 across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, W'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, W'(8'h44 + i), 1'b1);
      chk("stream", "rd_size", int'(rd_size), 4);
      chk("stream", "rd_data", int'(rd_data), 8'h40 + i);
      chk_model("stream");
    end

    // Reset with five words stored discards them.
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("pre_rst", "rd_size", int'(rd_size), 5);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("mid_rst", "rd_size", int'(rd_size), 0);
    chk("mid_rst", "wr_size", int'(wr_size), 8);
    chk("mid_rst", "rd_data", int'(rd_data), 0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("post_rst", "rd_underflow", int'(rd_underflow), 1);
    chk_model("post_rst");

    // Random traffic: write-heavy, read-heavy, then balanced, rare resets.
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      logic r, we, re;
      wp = (i < 200) ? 75 : (i < 400) ? 30 : 55;
      rp = (i < 200) ? 30 : (i < 400) ? 75 : 55;
      r  = ($urandom_range(0, 149) != 0);
      we = ($urandom_range(0, 99) < wp);
      re = ($urandom_range(0, 99) < rp);
      step(r, we, W'($urandom), re);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
